// File: rtl/router_pkt_src_if.sv
// Router-facing byte link of the packet source: data and pkt_valid toward the router,
// busy and error back from it.
interface router_pkt_src_if;
    logic [7:0] rt_data;
    logic       pkt_valid;
    logic       busy;
    logic       error;

    modport master (output rt_data, output pkt_valid, input busy, input error);
    modport slave  (input rt_data, input pkt_valid, output busy, output error);
endinterface

// File: rtl/router_pkt_src.sv
// Store-and-forward packet source for the 1-to-3 router: buffers one request's payload, then sends
// header/payload/parity. Optional macro PARITY_CORRUPT_EN adds a corrupt_parity request input.
module router_pkt_src #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
`ifdef PARITY_CORRUPT_EN
    input  logic       corrupt_parity,
`endif
    router_pkt_src_if.master rt,
    output logic       done,
    output logic       pkt_err,
    output logic       addr_err
);

    localparam int DEPTH = MAX_LEN + 1;
    localparam int CW    = $clog2(ERR_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ERR_WAIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND_HDR, SEND_PL, SEND_PAR, CHK_ERR} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    addr_q;
    logic [5:0]    len_q;
    logic [5:0]    wr_cnt;
    logic [5:0]    rd_cnt;
    logic [7:0]    parity;
    logic [7:0]    parity_tx;
    logic [CW-1:0] cnt;
    logic [7:0]    rt_data_q;
    logic          pkt_valid_q;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    req_hdr;
    logic          last_wr;
    logic          last_rd;

    assign req_hdr      = {req_len, req_addr};
    assign last_wr      = (wr_cnt == len_q - 6'd1);
    assign last_rd      = (rd_cnt == len_q - 6'd1);
    assign req_ready    = (state == IDLE);
    assign pl_ready     = (state == LOAD);
    assign rt.rt_data   = rt_data_q;
    assign rt.pkt_valid = pkt_valid_q;

`ifdef PARITY_CORRUPT_EN
    logic corrupt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            corrupt_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            corrupt_q <= corrupt_parity;
        end
    end

    assign parity_tx = parity ^ {7'd0, corrupt_q};
`else
    assign parity_tx = parity;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid && req_addr != 2'd3) begin
                    state_nxt = (req_len == 6'd0) ? SEND_HDR : LOAD;
                end
            end
            LOAD:     if (pl_valid && last_wr) state_nxt = SEND_HDR;
            SEND_HDR: if (!rt.busy) state_nxt = (len_q == 6'd0) ? SEND_PAR : SEND_PL;
            SEND_PL:  if (!rt.busy && last_rd) state_nxt = SEND_PAR;
            SEND_PAR: if (!rt.busy) state_nxt = CHK_ERR;
            CHK_ERR:  if (cnt == CNT_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Payload storage needs no reset; it is always rewritten before it is read.
    always_ff @(posedge clock) begin
        if (state == LOAD && pl_valid) begin
            mem[wr_cnt] <= pl_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rt_data_q   <= 8'd0;
            pkt_valid_q <= 1'b0;
            done        <= 1'b0;
            pkt_err     <= 1'b0;
            addr_err    <= 1'b0;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wr_cnt      <= 6'd0;
            rd_cnt      <= 6'd0;
            parity      <= 8'd0;
            cnt         <= '0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        len_q   <= req_len;
                        parity  <= req_hdr;
                        pkt_err <= 1'b0;
                        wr_cnt  <= 6'd0;
                        rd_cnt  <= 6'd0;
                        if (req_addr == 2'd3) begin
                            addr_err <= 1'b1;
                        end else if (req_len == 6'd0) begin
                            rt_data_q   <= req_hdr;
                            pkt_valid_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        parity <= parity ^ pl_data;
                        wr_cnt <= wr_cnt + 6'd1;
                        if (last_wr) begin
                            rt_data_q   <= {len_q, addr_q};
                            pkt_valid_q <= 1'b1;
                        end
                    end
                end
                SEND_HDR: begin
                    if (!rt.busy) begin
                        if (len_q == 6'd0) begin
                            rt_data_q   <= parity_tx;
                            pkt_valid_q <= 1'b0;
                        end else begin
                            rt_data_q <= mem[0];
                            rd_cnt    <= 6'd0;
                        end
                    end
                end
                SEND_PL: begin
                    if (!rt.busy) begin
                        if (last_rd) begin
                            rt_data_q   <= parity_tx;
                            pkt_valid_q <= 1'b0;
                        end else begin
                            rd_cnt    <= rd_cnt + 6'd1;
                            rt_data_q <= mem[rd_cnt + 6'd1];
                        end
                    end
                end
                SEND_PAR: begin
                    if (!rt.busy) begin
                        rt_data_q <= 8'd0;
                        cnt       <= '0;
                    end
                end
                CHK_ERR: begin
                    pkt_err <= pkt_err | rt.error;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed self-checking bench for router_pkt_src; inputs change and outputs are sampled on the falling edge.
module tb_router_pkt_src;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       corrupt_parity;
    logic       done;
    logic       pkt_err;
    logic       addr_err;

    int vectors    = 0;
    int miscompares = 0;

    router_pkt_src_if rif ();

    router_pkt_src dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
`ifdef PARITY_CORRUPT_EN
        .corrupt_parity (corrupt_parity),
`endif
        .rt        (rif.master),
        .done      (done),
        .pkt_err   (pkt_err),
        .addr_err  (addr_err)
    );

    always #5 clock = ~clock;

    // Called on a falling edge; returns on the falling edge after the request was accepted.
    task automatic issue_req(input logic [1:0] a, input logic [5:0] l, input logic c);
        req_valid      = 1'b1;
        req_addr       = a;
        req_len        = l;
        corrupt_parity = c;
        @(negedge clock);
        req_valid      = 1'b0;
        corrupt_parity = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        pl_valid = 1'b1;
        pl_data  = d;
        @(negedge clock);
        pl_valid = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (rif.rt_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rt_data: got %h want 00", rif.rt_data); end
        vectors++; if (rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pkt_valid: got %b want 0", rif.pkt_valid); end
        vectors++; if ({done, pkt_err, addr_err} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_status: got %b want 000", {done, pkt_err, addr_err}); end
        vectors++; if ({req_ready, pl_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 10", {req_ready, pl_ready}); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        logic       exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        issue_req(2'd1, 6'd3, 1'b0);
        vectors++; if (pl_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_pl_ready: got %b want 1", pl_ready); end
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            vectors++; if (rif.rt_data !== exp_d[i] || rif.pkt_valid !== exp_v[i]) begin miscompares++; $display("[TB] FAIL basic_byte%0d: got %h/%b want %h/%b", i, rif.rt_data, rif.pkt_valid, exp_d[i], exp_v[i]); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL basic_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_pkt_err: got %b want 0", pkt_err); end
        @(negedge clock);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_stall();
        issue_req(2'd1, 6'd3, 1'b0);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        vectors++; if (rif.rt_data !== 8'h0D || rif.pkt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_hdr: got %h/%b want 0D/1", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h11) begin miscompares++; $display("[TB] FAIL stall_b0: got %h want 11", rif.rt_data); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h22) begin miscompares++; $display("[TB] FAIL stall_b1: got %h want 22", rif.rt_data); end
        rif.busy = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            vectors++; if (rif.rt_data !== 8'h22 || rif.pkt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_hold%0d: got %h/%b want 22/1", s, rif.rt_data, rif.pkt_valid); end
        end
        rif.busy = 1'b0;
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h33 || rif.pkt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_b2: got %h/%b want 33/1", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h0D || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_par: got %h/%b want 0D/0", rif.rt_data, rif.pkt_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL stall_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        @(negedge clock);
    endtask

    task automatic test_len0();
        issue_req(2'd2, 6'd0, 1'b0);
        vectors++; if (rif.rt_data !== 8'h02 || rif.pkt_valid !== 1'b1 || pl_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_hdr: got %h/%b pl_ready %b want 02/1 pl_ready 0", rif.rt_data, rif.pkt_valid, pl_ready); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h02 || rif.pkt_valid !== 1'b0 || pl_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_par: got %h/%b pl_ready %b want 02/0 pl_ready 0", rif.rt_data, rif.pkt_valid, pl_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL len0_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        @(negedge clock);
    endtask

    task automatic test_bad_addr();
        issue_req(2'd3, 6'd5, 1'b0);
        vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("[TB] FAIL badaddr_pulse: got %b want 1", addr_err); end
        vectors++; if ({req_ready, pl_ready, rif.pkt_valid} !== 3'b100) begin miscompares++; $display("[TB] FAIL badaddr_idle: got %b want 100", {req_ready, pl_ready, rif.pkt_valid}); end
        @(negedge clock);
        vectors++; if ({addr_err, pl_ready, rif.pkt_valid} !== 3'b000) begin miscompares++; $display("[TB] FAIL badaddr_after: got %b want 000", {addr_err, pl_ready, rif.pkt_valid}); end
    endtask

    task automatic test_error();
        issue_req(2'd1, 6'd3, 1'b0);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        repeat (4) @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h0D || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL err_par: got %h/%b want 0D/0", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        @(negedge clock);
        rif.error = 1'b1;
        @(negedge clock);
        rif.error = 1'b0;
        @(negedge clock);
        vectors++; if (done !== 1'b1 || pkt_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_status: got done %b pkt_err %b want 1 1", done, pkt_err); end
        issue_req(2'd2, 6'd0, 1'b0);
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear: got %b want 0", pkt_err); end
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL err_next_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_next_clean: got %b want 0", pkt_err); end
        @(negedge clock);
    endtask

    task automatic test_midpacket_reset();
        issue_req(2'd1, 6'd3, 1'b0);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        @(negedge clock);
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h22) begin miscompares++; $display("[TB] FAIL rst_pre: got %h want 22", rif.rt_data); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (rif.rt_data !== 8'h00 || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async: got %h/%b want 00/0", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        vectors++; if (req_ready !== 1'b1 || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_idle: got req_ready %b pv %b want 1 0", req_ready, rif.pkt_valid); end
        issue_req(2'd0, 6'd1, 1'b0);
        push_byte(8'hAA);
        vectors++; if (rif.rt_data !== 8'h04 || rif.pkt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_new_hdr: got %h/%b want 04/1", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'hAA || rif.pkt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_new_pl: got %h/%b want AA/1", rif.rt_data, rif.pkt_valid); end
        @(negedge clock);
        vectors++; if (rif.rt_data !== 8'hAE || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_new_par: got %h/%b want AE/0", rif.rt_data, rif.pkt_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL rst_new_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        @(negedge clock);
    endtask

`ifdef PARITY_CORRUPT_EN
    task automatic test_corrupt();
        issue_req(2'd1, 6'd3, 1'b1);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        vectors++; if (rif.rt_data !== 8'h0D) begin miscompares++; $display("[TB] FAIL corrupt_hdr: got %h want 0D", rif.rt_data); end
        repeat (4) @(negedge clock);
        vectors++; if (rif.rt_data !== 8'h0C || rif.pkt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL corrupt_par: got %h/%b want 0C/0", rif.rt_data, rif.pkt_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++; if (done !== (k == 3)) begin miscompares++; $display("[TB] FAIL corrupt_done_c%0d: got %b want %b", k + 1, done, (k == 3)); end
        end
        @(negedge clock);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn         = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 2'd0;
        req_len        = 6'd0;
        pl_valid       = 1'b0;
        pl_data        = 8'd0;
        corrupt_parity = 1'b0;
        rif.busy       = 1'b0;
        rif.error      = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        resetn = 1'b1;
        @(negedge clock);
        test_basic();
        test_stall();
        test_len0();
        test_bad_addr();
        test_error();
        test_midpacket_reset();
`ifdef PARITY_CORRUPT_EN
        test_corrupt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
